// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : controller_pkg
//  Brief    : Shared button constants, event record type and encoder helper.
//  Revision : 1.0 - initial release
// ============================================================================
package controller_pkg;

  localparam int NUM_BUTTONS = 8;
  localparam logic [NUM_BUTTONS-1:0] BTN_RELEASED = 8'hFF;

  typedef struct packed {
    logic       rpt;
    logic       pressed;
    logic [2:0] idx;
  } btn_evt_t;

  // Lowest set bit wins so simultaneous changes drain in index order.
  function automatic logic [2:0] lowest_set_idx(input logic [NUM_BUTTONS-1:0] vec);
    lowest_set_idx = 3'd0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set_idx = 3'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock first-word-fall-through FIFO with occupancy count.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == (c_AW + 1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/button_event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_queue
//  Brief    : Turns sampled active-low button levels into an ordered stream
//             of press/release events queued behind a valid/ready pop port.
//             Define BUTTON_AUTOREPEAT_EN to add held-button repeat events.
//  Revision : 1.0 - initial release
// ============================================================================
module button_event_queue
  import controller_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int CNT_BITS      = 25,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_BUTTONS-1:0]   buttons,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [4:0]               evt_data,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic [NUM_BUTTONS-1:0]   held,
  output logic                     stall
);

  localparam bit c_CFG_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) &&
                            (CNT_BITS > 0) && (CNT_BITS <= 32) &&
                            (REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0);

  if (!c_CFG_OK) begin : g_cfg_check
    $error("button_event_queue: illegal parameter combination");
  end

  logic [NUM_BUTTONS-1:0] r_btn_q;
  logic [NUM_BUTTONS-1:0] r_reported;
  logic [NUM_BUTTONS-1:0] w_diff;
  logic [2:0]             w_idx;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_diff_push;
  logic                   w_rpt_push;
  logic                   w_push;
  btn_evt_t               w_diff_evt;
  btn_evt_t               w_rpt_evt;
  btn_evt_t               w_push_evt;
  logic [4:0]             w_fifo_data;

  assign w_diff      = r_btn_q ^ r_reported;
  assign w_idx       = lowest_set_idx(w_diff);
  assign w_diff_push = (w_diff != '0) && !w_full;

  always_comb begin
    w_diff_evt         = '0;
    w_diff_evt.pressed = ~r_btn_q[w_idx];
    w_diff_evt.idx     = w_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_q    <= BTN_RELEASED;
      r_reported <= BTN_RELEASED;
    end else begin
      r_btn_q <= buttons;
      if (w_diff_push) r_reported[w_idx] <= r_btn_q[w_idx];
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  // Loads are one less than the interval so repeats land exactly
  // REPEAT_DELAY / REPEAT_PERIOD cycles apart.
  localparam logic [CNT_BITS-1:0] c_DELAY_LOAD  = CNT_BITS'(REPEAT_DELAY - 1);
  localparam logic [CNT_BITS-1:0] c_PERIOD_LOAD = CNT_BITS'(REPEAT_PERIOD - 1);

  logic [CNT_BITS-1:0] r_rpt_cnt;
  logic                r_rpt_vld;
  logic [2:0]          r_rpt_tgt;
  logic                w_rpt_due;

  assign w_rpt_due  = r_rpt_vld && !r_reported[r_rpt_tgt] && (r_rpt_cnt == '0);
  assign w_rpt_push = w_rpt_due && !w_diff_push && !w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rpt_cnt <= '0;
      r_rpt_vld <= 1'b0;
      r_rpt_tgt <= '0;
    end else if (w_diff_push && w_diff_evt.pressed) begin
      r_rpt_tgt <= w_idx;
      r_rpt_vld <= 1'b1;
      r_rpt_cnt <= c_DELAY_LOAD;
    end else begin
      if (w_diff_push && (w_idx == r_rpt_tgt)) r_rpt_vld <= 1'b0;
      if (r_rpt_vld && !r_reported[r_rpt_tgt]) begin
        if (r_rpt_cnt != '0)  r_rpt_cnt <= r_rpt_cnt - 1'b1;
        else if (w_rpt_push)  r_rpt_cnt <= c_PERIOD_LOAD;
      end
    end
  end

  always_comb begin
    w_rpt_evt         = '0;
    w_rpt_evt.rpt     = 1'b1;
    w_rpt_evt.pressed = 1'b1;
    w_rpt_evt.idx     = r_rpt_tgt;
  end
`else
  assign w_rpt_push = 1'b0;
  assign w_rpt_evt  = '0;
`endif

  assign w_push     = w_diff_push || w_rpt_push;
  assign w_push_evt = w_diff_push ? w_diff_evt : w_rpt_evt;

  sync_fifo #(
    .WIDTH (5),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_evt),
    .i_pop   (evt_ready),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (evt_count)
  );

  assign evt_valid = !w_empty;
  assign evt_data  = w_fifo_data;
  assign held      = ~r_reported;
  assign stall     = (w_diff != '0) && w_full;

endmodule
`default_nettype wire
